// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   fetch_state_e  - FSM state encoding (IDLE / FETCH / HOLD)
//   PC_INCREMENT   - byte distance between sequential instructions
//   NOP_INSTR      - value the IF/ID instruction register resets to
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INCREMENT = 4;
    localparam int unsigned NOP_INSTR    = 0;

endpackage

// File: rtl/instr_fetch_unit_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry buffer that parks a memory response when the IF/ID register is
// occupied and stalled. The entry packs {instr, pc4} into W+N bits.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_load               capture {i_instr, i_pc4}
//   i_drain              entry consumed by IF/ID, buffer empties
//   i_flush              discard entry (highest priority)
//   o_valid              entry is occupied
//   o_instr, o_pc4       stored entry fields
// -----------------------------------------------------------------------------
module fetch_skid_buffer #(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_instr,
    input  logic [N-1:0] i_pc4,
    input  logic         i_drain,
    input  logic         i_flush,
    output logic         o_valid,
    output logic [W-1:0] o_instr,
    output logic [N-1:0] o_pc4
);

    logic             r_valid;
    logic [W+N-1:0]   r_entry;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= {i_instr, i_pc4};
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_entry[W+N-1:N];
    assign o_pc4   = r_entry[N-1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage: issues requests to instruction memory at the
// current PC, computes the next PC, and fills the IF/ID pipeline register.
// A one-entry skid buffer absorbs a response that arrives while decode is
// stalled; redirects (branches/jumps) flush IF/ID and steer the next PC.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   pc_value / new_pc          current PC in, next PC out (combinational)
//   redirect, redirect_pc      taken branch/jump and its target
//   imem_req, imem_addr        memory request (addr == pc_value)
//   imem_ready, imem_rdata     memory handshake and instruction data
//   if_id_stall                decode cannot accept a new instruction
//   if_id_valid/instr/pc4      IF/ID pipeline register
//
// Optional build macro FETCH_PERF_CNT_EN adds 32-bit counters:
//   fetch_count  accepted IF/ID loads
//   wait_count   cycles with imem_req=1 and imem_ready=0
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_value,
    output logic [N-1:0] new_pc,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [W-1:0] imem_rdata,
    input  logic         if_id_stall,
    output logic         if_id_valid,
    output logic [W-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  wait_count
`endif
);

    fetch_state_e r_state;
    logic         r_imem_req;
    logic         r_pend_vld;
    logic [N-1:0] r_pend_pc;
    logic         r_if_id_valid;
    logic [W-1:0] r_if_id_instr;
    logic [N-1:0] r_if_id_pc4;

    logic [N-1:0] w_pc4;
    logic         w_xfer;
    logic         w_slot_busy;
    logic         w_discard;
    logic         w_fetch_load;
    logic         w_skid_load;
    logic         w_skid_drain;
    logic         w_ifid_load;
    logic         w_skid_valid;
    logic [W-1:0] w_skid_instr;
    logic [N-1:0] w_skid_pc4;
    logic [W-1:0] w_ifid_instr_d;
    logic [N-1:0] w_ifid_pc4_d;

    // Modulo 2^N increment; wrap-around is silent by design.
    assign w_pc4       = pc_value + N'(PC_INCREMENT);
    assign w_xfer      = r_imem_req & imem_ready;
    assign w_slot_busy = r_if_id_valid & if_id_stall;

    // A response is stale if a redirect is live or was seen while waiting.
    assign w_discard    = w_xfer & (redirect | r_pend_vld);
    assign w_fetch_load = w_xfer & ~w_discard & ~w_slot_busy;
    assign w_skid_load  = w_xfer & ~w_discard &  w_slot_busy;
    assign w_skid_drain = (r_state == ST_HOLD) & ~if_id_stall & ~redirect;
    assign w_ifid_load  = w_fetch_load | w_skid_drain;

    assign w_ifid_instr_d = w_skid_drain ? w_skid_instr : imem_rdata;
    assign w_ifid_pc4_d   = w_skid_drain ? w_skid_pc4   : w_pc4;

    fetch_skid_buffer #(
        .N (N),
        .W (W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_skid_load),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc4),
        .i_drain (w_skid_drain),
        .i_flush (redirect),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc4   (w_skid_pc4)
    );

    // Next-PC selection. The PC register has no enable, so every cycle that
    // does not advance must feed pc_value back, which also keeps imem_addr
    // stable while a request waits for imem_ready.
    always_comb begin
        new_pc = pc_value;
        unique case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (redirect) new_pc = redirect_pc;
            end
            ST_FETCH: begin
                if (w_xfer) begin
                    if (redirect)        new_pc = redirect_pc;
                    else if (r_pend_vld) new_pc = r_pend_pc;
                    else                 new_pc = w_pc4;
                end
            end
            default: new_pc = pc_value;
        endcase
    end

    // Control FSM with registered request output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_imem_req <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (w_xfer) begin
                        r_pend_vld <= 1'b0;
                        if (w_skid_load) begin
                            r_state    <= ST_HOLD;
                            r_imem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request must stay stable, so remember the target
                        // and apply it when the outstanding transfer completes.
                        r_pend_vld <= 1'b1;
                        r_pend_pc  <= redirect_pc;
                    end
                end
                ST_HOLD: begin
                    if (redirect || !if_id_stall) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush beats load beats hold; an unstalled slot with
    // nothing new to load empties because decode consumed it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= W'(NOP_INSTR);
            r_if_id_pc4   <= '0;
        end else if (redirect) begin
            r_if_id_valid <= 1'b0;
        end else if (w_ifid_load) begin
            r_if_id_valid <= 1'b1;
            r_if_id_instr <= w_ifid_instr_d;
            r_if_id_pc4   <= w_ifid_pc4_d;
        end else if (!if_id_stall) begin
            r_if_id_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_wait_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
            r_wait_count  <= '0;
        end else begin
            if (w_ifid_load)              r_fetch_count <= r_fetch_count + 32'd1;
            if (r_imem_req && !imem_ready) r_wait_count  <= r_wait_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign wait_count  = r_wait_count;
`endif

    assign imem_req    = r_imem_req;
    assign imem_addr   = pc_value;
    assign if_id_valid = r_if_id_valid;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc4   = r_if_id_pc4;

    // Skid occupancy mirrors the HOLD state; kept for visibility only.
    logic w_unused;
    assign w_unused = w_skid_valid;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter N, default 32, PC/address width in bits.
REQ-002 Parameter W, default 32, instruction width in bits.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately, independent of clk.
REQ-005 pc_value  input  N  current PC from the PC register.
REQ-006 new_pc  output  N  next PC to the PC register, combinational; the PC register has no enable, so "hold" means new_pc=pc_value.
REQ-007 redirect  input  1  branch/jump taken this cycle.
REQ-008 redirect_pc  input  N  target PC, valid when redirect=1.
REQ-009 imem_req  output  1  instruction-memory request valid.
REQ-010 imem_addr  output  N  request address; equals pc_value.
REQ-011 imem_ready  input  1  memory accepts the request and returns data; transfer = imem_req&imem_ready in the same cycle.
REQ-012 imem_rdata  input  W  instruction; valid only in the transfer cycle.
REQ-013 if_id_stall  input  1  decode cannot accept a new instruction.
REQ-014 if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-015 if_id_instr  output  W  registered instruction.
REQ-016 if_id_pc4  output  N  registered pc_value+4 of that instruction.

Function
REQ-017 FSM states: IDLE, FETCH, HOLD; imem_req=1 only in FETCH.
REQ-018 IDLE lasts exactly one cycle after reset release, then goes to FETCH; new_pc=pc_value in IDLE.
REQ-019 In FETCH, once asserted, imem_req and imem_addr stay stable until transfer, regardless of redirect or stall.
REQ-020 Non-transfer cycle in FETCH: new_pc=pc_value.
REQ-021 Transfer with no redirect, no pending redirect, and an IF/ID slot free (if_id_valid=0 or if_id_stall=0): IF/ID loads {imem_rdata, pc_value+4}, if_id_valid=1 at next edge, new_pc=pc_value+4, FSM stays in FETCH.
REQ-022 Transfer while if_id_valid=1 and if_id_stall=1: response goes into a one-entry skid buffer, new_pc=pc_value+4, FSM goes to HOLD.
REQ-023 In HOLD: new_pc=pc_value; when if_id_stall=0, IF/ID loads the skid entry, skid empties, FSM goes to FETCH.
REQ-024 redirect=1 in FETCH with no transfer: latch redirect_pc into pending register, set pending flag, new_pc=pc_value.
REQ-025 Transfer with redirect=1 or pending flag set: discard response, new_pc=redirect_pc (live input takes priority over pending), clear pending flag.
REQ-026 redirect=1 in HOLD or IDLE: discard skid, new_pc=redirect_pc, FSM goes to FETCH.
REQ-027 Any redirect=1 clears if_id_valid at the next edge (flush), overriding any IF/ID load and if_id_stall.
REQ-028 if_id_valid=1 and if_id_stall=1: if_id_instr and if_id_pc4 hold their values.
REQ-029 Adders are N-bit modulo 2^N: pc_value=2^N-4 gives pc4=0, with no flag.

Reset
REQ-030 While reset==0: state=IDLE, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc4=0, skid empty, pending flag=0, pending PC=0.
REQ-031 Reset asserted mid-transfer abandons the request; nothing is replayed after release.

Configuration
REQ-032 With FETCH_PERF_CNT_EN defined: the block has 32-bit outputs fetch_count (counts accepted IF/ID loads) and wait_count (counts cycles with imem_req=1 and imem_ready=0).
REQ-033 Both counters reset to 0 and wrap modulo 2^32.
REQ-034 Without FETCH_PERF_CNT_EN: both ports and their logic are absent; all other behaviour is identical.

Structure
REQ-035 A shared package holds the FSM state typedef/encoding, PC_INCREMENT=4, and NOP_INSTR=0.
REQ-036 The skid buffer is a sub-module fetch_skid_buffer (one entry, W+N bits, valid flag, load/drain/flush).

Verification
REQ-037 Reset release with pc_value=0x00040000 and imem_ready=1 always: imem_req rises 1 cycle after IDLE; new_pc=0x00040004; if_id_valid=1 with if_id_pc4=0x00040004 one cycle later.
REQ-038 imem_ready low for 3 cycles: imem_addr constant for 4 cycles; new_pc=pc_value throughout; with FETCH_PERF_CNT_EN, wait_count=3.
REQ-039 if_id_stall=1 while valid, plus a transfer with imem_rdata=0x8C080000: FSM enters HOLD, IF/ID unchanged; stall drop loads 0x8C080000 next edge.
REQ-040 redirect=1 to 0x00040100 during a 2-cycle wait: addr held; at transfer, data dropped and new_pc=0x00040100; if_id_valid=0 after the redirect edge.
REQ-041 Simultaneous transfer and redirect to 0x00040200 in HOLD-free FETCH: response discarded, new_pc=0x00040200, if_id_valid=0 next cycle.
REQ-042 reset pulsed low mid-wait: all outputs go to reset values immediately; restart from IDLE.
